// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - shared SD CMD-line constants, state encoding and CRC7 step
package sd_pkg;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_WAIT_START = 2'd1;
  localparam logic [1:0] ST_RECEIVE    = 2'd2;
  localparam logic [1:0] ST_CHECK      = 2'd3;

  localparam int SHORT_LEN = 48;
  localparam int LONG_LEN  = 136;

  localparam logic [6:0] CRC7_POLY = 7'h09;

  localparam int SHORT_TX_BIT  = 46;
  localparam int LONG_TX_BIT   = 134;
  localparam int SHORT_CRC_TOP = 47;
  localparam int LONG_CRC_TOP  = 127;
  localparam int CRC_BOTTOM    = 8;
  localparam int CRC_MSB       = 7;
  localparam int CRC_LSB       = 1;

  typedef struct packed {
    logic timeout;
    logic crc;
    logic end_bit;
    logic tx;
  } resp_err_t;

  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    crc7_step = {crc[5:0], 1'b0} ^ ((crc[6] ^ din) ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_resp_ctrl_if.sv
// rtl/sd_resp_ctrl_if.sv - request/result handshake between command FSM and response controller
interface sd_resp_ctrl_if #(
  parameter int BITS = 136
);
  logic            start;
  logic            long_resp;
  logic            check_crc;
  logic            abort;
  logic            cmd_in;
  logic            busy;
  logic            done;
  logic [BITS-1:0] resp;
  logic            err_timeout;
  logic            err_crc;
  logic            err_end;
  logic            err_tx;

  modport master (
    output start, long_resp, check_crc, abort, cmd_in,
    input  busy, done, resp, err_timeout, err_crc, err_end, err_tx
  );

  modport slave (
    input  start, long_resp, check_crc, abort, cmd_in,
    output busy, done, resp, err_timeout, err_crc, err_end, err_tx
  );
endinterface

// File: rtl/sd_crc7.sv
// rtl/sd_crc7.sv - serial CRC7 (x^7+x^3+1) with synchronous clear and enable
module sd_crc7
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic       data_in,
  output logic [6:0] crc
);

  logic [6:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clear) begin
      crc_d = '0;
    end else if (enable) begin
      crc_d = crc7_step(crc_q, data_in);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/sd_resp_ctrl.sv
// rtl/sd_resp_ctrl.sv - SD CMD-line response capture with tx/CRC7/end-bit checks, timeout and abort
module sd_resp_ctrl
  import sd_pkg::*;
#(
  parameter int BITS       = LONG_LEN,
  parameter int SHORT_BITS = SHORT_LEN,
  parameter int TIMEOUT    = 64,
  parameter int CNT_W      = 8
) (
  input  logic          clk,
  input  logic          reset,
  sd_resp_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] LEN_LONG  = CNT_W'(BITS);
  localparam logic [CNT_W-1:0] LEN_SHORT = CNT_W'(SHORT_BITS);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic             long_q, long_d;
  logic             chk_q, chk_d;
  logic [BITS-1:0]  resp_q, resp_d;
  resp_err_t        err_q, err_d;
  logic [CNT_W-1:0] bitcnt_q, bitcnt_d;
  logic [CNT_W-1:0] tocnt_q, tocnt_d;
  logic             done_q, done_d;

  logic [CNT_W-1:0] frame_len, frame_idx, crc_top;
  logic             crc_clear, crc_en;
  logic [6:0]       crc;

  // frame_idx is the frame bit number of the bit being sampled this cycle
  assign frame_len = long_q ? LEN_LONG : LEN_SHORT;
  assign frame_idx = frame_len - CNT_W'(1) - bitcnt_q;
  assign crc_top   = long_q ? CNT_W'(LONG_CRC_TOP) : CNT_W'(SHORT_CRC_TOP);

  always_comb begin
    state_d   = state_q;
    long_d    = long_q;
    chk_d     = chk_q;
    resp_d    = resp_q;
    err_d     = err_q;
    bitcnt_d  = bitcnt_q;
    tocnt_d   = tocnt_q;
    done_d    = 1'b0;
    crc_clear = 1'b0;
    crc_en    = 1'b0;

    if (bus.abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            long_d   = bus.long_resp;
            chk_d    = bus.check_crc;
            resp_d   = '0;
            err_d    = '0;
            bitcnt_d = '0;
            tocnt_d  = '0;
            state_d  = ST_WAIT_START;
          end
        end
        ST_WAIT_START: begin
          if (!bus.cmd_in) begin
            // the start bit is 0, so clearing instead of feeding it leaves the CRC identical
            resp_d    = {resp_q[BITS-2:0], bus.cmd_in};
            bitcnt_d  = CNT_W'(1);
            crc_clear = 1'b1;
            state_d   = ST_RECEIVE;
          end else if (tocnt_q == TO_LAST) begin
            err_d.timeout = 1'b1;
            done_d        = 1'b1;
            state_d       = ST_IDLE;
          end else begin
            tocnt_d = tocnt_q + CNT_W'(1);
          end
        end
        ST_RECEIVE: begin
          resp_d   = {resp_q[BITS-2:0], bus.cmd_in};
          bitcnt_d = bitcnt_q + CNT_W'(1);
          crc_en   = (frame_idx >= CNT_W'(CRC_BOTTOM)) && (frame_idx <= crc_top);
          if (bitcnt_d == frame_len) begin
            state_d = ST_CHECK;
          end
        end
        ST_CHECK: begin
          err_d.tx      = long_q ? resp_q[LONG_TX_BIT] : resp_q[SHORT_TX_BIT];
          err_d.end_bit = ~resp_q[0];
          err_d.crc     = chk_q && (crc != resp_q[CRC_MSB:CRC_LSB]);
          done_d        = 1'b1;
          state_d       = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      long_q   <= 1'b0;
      chk_q    <= 1'b0;
      resp_q   <= '0;
      err_q    <= '0;
      bitcnt_q <= '0;
      tocnt_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      long_q   <= long_d;
      chk_q    <= chk_d;
      resp_q   <= resp_d;
      err_q    <= err_d;
      bitcnt_q <= bitcnt_d;
      tocnt_q  <= tocnt_d;
      done_q   <= done_d;
    end
  end

  sd_crc7 u_crc7 (
    .clk     (clk),
    .reset   (reset),
    .clear   (crc_clear),
    .enable  (crc_en),
    .data_in (bus.cmd_in),
    .crc     (crc)
  );

  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.done        = done_q;
  assign bus.resp        = resp_q;
  assign bus.err_timeout = err_q.timeout;
  assign bus.err_crc     = err_q.crc;
  assign bus.err_end     = err_q.end_bit;
  assign bus.err_tx      = err_q.tx;

endmodule

// File: tb/tb_sd_resp_ctrl.sv
// tb/tb_sd_resp_ctrl.sv - scoreboard bench for sd_resp_ctrl with a polynomial-division CRC7 model
module tb_sd_resp_ctrl;

  localparam int TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sd_resp_ctrl_if #(.BITS(136)) bus ();

  sd_resp_ctrl #(
    .BITS       (136),
    .SHORT_BITS (48),
    .TIMEOUT    (TIMEOUT),
    .CNT_W      (8)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int           cyc;
    logic [135:0] resp;
    logic [3:0]   flags;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [135:0] act, input logic [135:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endfunction

  function automatic logic [3:0] flags_now();
    return {bus.err_timeout, bus.err_crc, bus.err_end, bus.err_tx};
  endfunction

  // remainder of M(x)*x^7 divided by x^7+x^3+1, M = frame bits hi..lo
  function automatic logic [6:0] crc7_div(input logic [135:0] f, input int hi, input int lo);
    logic [142:0] m;
    m = '0;
    for (int i = hi; i >= lo; i--) m = {m[141:0], f[i]};
    m = m << 7;
    for (int b = 142; b >= 7; b--) begin
      if (m[b]) m[b -: 8] = m[b -: 8] ^ 8'h89;
    end
    return m[6:0];
  endfunction

  // corrupt: 1 bad CRC, 2 end bit 0, 3 tx bit 1, anything else a clean frame
  function automatic logic [135:0] gen(input logic lng, input int corrupt);
    logic [135:0] f;
    logic [127:0] r;
    int len;
    len = lng ? 136 : 48;
    r = {$urandom, $urandom, $urandom, $urandom};
    f = '0;
    if (lng) begin
      f[133:128] = 6'h3F;
      f[127:8]   = r[119:0];
      f[7:1]     = crc7_div(f, 127, 8);
    end else begin
      f[45:8] = r[37:0];
      f[7:1]  = crc7_div(f, 47, 8);
    end
    f[0] = 1'b1;
    case (corrupt)
      1: f[7:1] = f[7:1] ^ 7'($urandom_range(1, 127));
      2: f[0] = 1'b0;
      3: f[len-2] = 1'b1;
      default: ;
    endcase
    return f;
  endfunction

  function automatic exp_t model(input logic lng, input logic chk, input logic [135:0] f,
                                 input int n_idle, input int e0);
    exp_t e;
    int len;
    logic [6:0] c;
    len = lng ? 136 : 48;
    if (n_idle >= TIMEOUT) begin
      e.cyc   = e0 + TIMEOUT;
      e.resp  = '0;
      e.flags = 4'b1000;
    end else begin
      c       = crc7_div(f, lng ? 127 : 47, 8);
      e.cyc   = e0 + 1 + n_idle + len;
      e.resp  = f;
      e.flags = {1'b0, chk && (c != f[7:1]), ~f[0], f[len-2]};
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      check("done_not_back_to_back", 136'(prev_done), 136'(1'b0));
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, required no result", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("done_cycle", 136'(cyc), 136'(mon_e.cyc));
        check("resp", bus.resp, mon_e.resp);
        check("err_flags", 136'(flags_now()), 136'(mon_e.flags));
      end
    end
    prev_done = bus.done;
  end

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!seen) begin
      n_errors++;
      $display("FAIL done_wait: got no done in 400 cycles, required a done pulse");
    end
  endtask

  // n_idle >= TIMEOUT means no start bit is ever sent
  task automatic run_frame(input logic lng, input logic chk, input int n_idle, input logic [135:0] f,
                           input bit use_model, input logic [135:0] c_resp, input logic [3:0] c_flags);
    exp_t e;
    int len;
    len = lng ? 136 : 48;
    bus.start     = 1'b1;
    bus.long_resp = lng;
    bus.check_crc = chk;
    bus.cmd_in    = 1'b1;
    @(posedge clk); #1;
    e = model(lng, chk, f, n_idle, cyc);
    if (!use_model) begin
      e.resp  = c_resp;
      e.flags = c_flags;
    end
    exp_q.push_back(e);
    bus.start = 1'b0;
    for (int i = 0; i < ((n_idle < TIMEOUT) ? n_idle : TIMEOUT); i++) begin
      @(posedge clk); #1;
    end
    if (n_idle < TIMEOUT) begin
      for (int i = len - 1; i >= 0; i--) begin
        bus.cmd_in    = f[i];
        bus.start     = ($urandom_range(0, 15) == 0);
        bus.long_resp = 1'($urandom_range(0, 1));
        bus.check_crc = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
    end
    bus.start  = 1'b0;
    bus.cmd_in = 1'b1;
    wait_done();
  endtask

  task automatic partial_frame(input logic [135:0] f);
    bus.start     = 1'b1;
    bus.long_resp = 1'b0;
    bus.check_crc = 1'b1;
    bus.cmd_in    = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    for (int i = 0; i < 20; i++) begin
      bus.cmd_in = f[47-i];
      @(posedge clk); #1;
    end
  endtask

  logic [135:0] f;
  logic         lng, chk;
  int           n;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    bus.start = 1'b0; bus.long_resp = 1'b0; bus.check_crc = 1'b0;
    bus.abort = 1'b0; bus.cmd_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 136'(bus.busy), 136'(1'b0));
    check("reset_done", 136'(bus.done), 136'(1'b0));
    check("reset_resp", bus.resp, 136'(0));
    check("reset_flags", 136'(flags_now()), 136'(4'b0000));
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_busy", 136'(bus.busy), 136'(1'b0));

    run_frame(1'b0, 1'b1, 5, 136'h08000001AA13, 1'b0, 136'h08000001AA13, 4'b0000);
    run_frame(1'b0, 1'b1, 5, 136'h08000001AA15, 1'b0, 136'h08000001AA15, 4'b0100);
    f = gen(1'b1, 0);
    run_frame(1'b1, 1'b1, 3, f, 1'b0, f, 4'b0000);
    run_frame(1'b0, 1'b1, TIMEOUT, '1, 1'b0, 136'(0), 4'b1000);
    run_frame(1'b0, 1'b0, 2, 136'h3F00FF8000FE, 1'b0, 136'h3F00FF8000FE, 4'b0010);
    f = gen(1'b0, 0);
    run_frame(1'b0, 1'b1, TIMEOUT - 1, f, 1'b0, f, 4'b0000);

    for (int t = 0; t < 30; t++) begin
      lng = 1'($urandom_range(0, 1));
      chk = 1'($urandom_range(0, 1));
      n   = ($urandom_range(0, 7) == 0) ? TIMEOUT : int'($urandom_range(0, 12));
      f   = gen(lng, int'($urandom_range(0, 5)));
      run_frame(lng, chk, n, f, 1'b1, '0, 4'b0000);
    end

    f = gen(1'b0, 0);
    partial_frame(f);
    bus.cmd_in = f[27];
    bus.abort  = 1'b1;
    @(posedge clk); #1;
    bus.abort  = 1'b0;
    bus.cmd_in = 1'b1;
    check("abort_busy", 136'(bus.busy), 136'(1'b0));
    check("abort_done", 136'(bus.done), 136'(1'b0));
    check("abort_resp_partial", bus.resp, f >> 28);
    check("abort_flags", 136'(flags_now()), 136'(4'b0000));
    repeat (5) @(negedge clk);
    f = gen(1'b0, 0);
    run_frame(1'b0, 1'b1, 4, f, 1'b1, '0, 4'b0000);

    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("start_abort_idle_busy", 136'(bus.busy), 136'(1'b0));
    @(posedge clk); #1;
    check("start_abort_idle_busy_later", 136'(bus.busy), 136'(1'b0));

    f = gen(1'b0, 0);
    partial_frame(f);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_busy", 136'(bus.busy), 136'(1'b0));
    check("midreset_done", 136'(bus.done), 136'(1'b0));
    check("midreset_resp", bus.resp, 136'(0));
    check("midreset_flags", 136'(flags_now()), 136'(4'b0000));
    @(posedge clk); #1;
    rst_n = 1'b1;
    f = gen(1'b1, 0);
    run_frame(1'b1, 1'b1, 1, f, 1'b1, '0, 4'b0000);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 136'(exp_q.size()), 136'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
